// File: rtl/demux32x4_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-entry holding register per lane.
// Define DEMUX_RR_EN to distribute words round-robin instead of by in_sel.
module demux32x4_stream #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic [1:0]           in_sel,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [1:0]           cur_lane,
    output logic [COUNT_W-1:0]   xfer_count
);

    logic [1:0]         lane_sel;
    logic               accept;
    logic [COUNT_W-1:0] xfer_count_reg;

`ifdef DEMUX_RR_EN
    logic [1:0] rr_ptr_reg;
    logic       unused_sel;

    // The pointer only advances on an accept, so a full lane stalls the stream rather than being skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= 2'd0;
        end else if (accept) begin
            rr_ptr_reg <= rr_ptr_reg + 2'd1;
        end
    end

    assign lane_sel   = rr_ptr_reg;
    assign unused_sel = ^in_sel;
`else
    assign lane_sel = in_sel;
`endif

    assign cur_lane = lane_sel;
    assign in_ready = ~out_valid[lane_sel] | out_ready[lane_sel];
    assign accept   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic             load;
            logic             pop;

            assign load = accept & (lane_sel == gi);
            assign pop  = valid_reg & out_ready[gi];

            // A load in the same cycle as a pop keeps the lane valid with the new word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (load) begin
                    valid_reg <= 1'b1;
                    data_reg  <= in_data;
                end else if (pop) begin
                    valid_reg <= 1'b0;
                end
            end

            assign out_valid[gi]                 = valid_reg;
            assign out_data[gi*WIDTH +: WIDTH]   = data_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_reg <= '0;
        end else if (accept) begin
            xfer_count_reg <= xfer_count_reg + 1'b1;
        end
    end

    assign xfer_count = xfer_count_reg;

endmodule

// File: tb/tb_demux32x4_stream.sv
// Directed self-checking bench for demux32x4_stream; a second instance with COUNT_W=4 checks counter wrap.
// The round-robin scenario runs when DEMUX_RR_EN is defined, the in_sel scenarios otherwise.
module tb_demux32x4_stream;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic [1:0]         in_sel;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [1:0]         cur_lane;
    logic [15:0]        xfer_count;

    logic               w_in_ready;
    logic [4*WIDTH-1:0] w_out_data;
    logic [3:0]         w_out_valid;
    logic [1:0]         w_cur_lane;
    logic [3:0]         w_xfer_count;

    int n_checks = 0;
    int n_fail   = 0;

    demux32x4_stream #(.WIDTH(WIDTH), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_sel(in_sel), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cur_lane(cur_lane),
        .xfer_count(xfer_count)
    );

    demux32x4_stream #(.WIDTH(WIDTH), .COUNT_W(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_sel(in_sel), .in_ready(w_in_ready), .out_data(w_out_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .cur_lane(w_cur_lane),
        .xfer_count(w_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] lane(input int idx);
        return out_data[idx*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word, checks it is accepted this cycle, then clocks it in.
    task automatic send(input logic [1:0] sel, input logic [31:0] data, input string tag);
        in_sel   = sel;
        in_data  = data;
        in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, in_ready, 1'b1);
        $display("xfer %s lane=%0d data=%h", tag, cur_lane, data);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        out_ready = 4'b0000;
        tick();
        tick();
        check("reset out_valid", out_valid, 4'b0000);
        check("reset xfer_count", xfer_count, 16'd0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_data", out_data, 128'd0);
        rst_n = 1'b1;
        tick();

`ifndef DEMUX_RR_EN
        // Basic routing
        out_ready = 4'b1111;
        send(2'd2, 32'hA0A0_A0A0, "route");
        check("route out_valid", out_valid, 4'b0100);
        check("route lane2", lane(2), 32'hA0A0_A0A0);
        check("route xfer_count", xfer_count, 16'd1);
        tick();
        check("route popped", out_valid, 4'b0000);
        check("route lane2 hold", lane(2), 32'hA0A0_A0A0);

        // Back-pressure on lane 1
        out_ready = 4'b1101;
        send(2'd1, 32'h1111_1111, "bp1");
        check("bp1 out_valid", out_valid, 4'b0010);
        check("bp1 xfer_count", xfer_count, 16'd2);
        in_sel   = 2'd1;
        in_data  = 32'h2222_2222;
        in_valid = 1'b1;
        #1;
        check("bp2 stalled in_ready", in_ready, 1'b0);
        tick();
        check("bp2 not consumed", xfer_count, 16'd2);
        check("bp2 lane1 first", lane(1), 32'h1111_1111);
        out_ready = 4'b1111;
        #1;
        check("bp2 released in_ready", in_ready, 1'b1);
        $display("xfer bp2 lane=1 data=22222222");
        tick();
        in_valid = 1'b0;
        check("bp2 pop+load out_valid", out_valid, 4'b0010);
        check("bp2 lane1 second", lane(1), 32'h2222_2222);
        check("bp2 xfer_count", xfer_count, 16'd3);
        tick();
        check("bp drained", out_valid, 4'b0000);

        // Lane independence with lane 0 stalled and full
        out_ready = 4'b1110;
        send(2'd0, 32'h0C0C_0C0C, "ind0");
        for (int k = 0; k < 8; k++) begin
            send((k % 2 == 0) ? 2'd2 : 2'd3, 32'h100 + k, $sformatf("ind%0d", k + 1));
        end
        check("ind out_valid", out_valid, 4'b1001);
        check("ind lane0 unchanged", lane(0), 32'h0C0C_0C0C);
        check("ind lane2", lane(2), 32'h106);
        check("ind lane3", lane(3), 32'h107);
        check("ind xfer_count", xfer_count, 16'd12);
        in_sel = 2'd0;
        #1;
        check("ind lane0 blocks", in_ready, 1'b0);

        // Reset mid-stream with lanes 1 and 3 full
        out_ready = 4'b0001;
        send(2'd1, 32'h5555_5555, "pre_rst");
        check("pre_rst out_valid", out_valid, 4'b1010);
        check("pre_rst xfer_count", xfer_count, 16'd13);
        out_ready = 4'b0000;
        in_sel    = 2'd1;
        rst_n     = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 4'b0000);
        check("async rst xfer_count", xfer_count, 16'd0);
        check("async rst in_ready", in_ready, 1'b1);
        check("async rst out_data", out_data, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst empty", out_valid, 4'b0000);

        // Counter wrap: 17 accepts
        out_ready = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            send(2'(k % 4), 32'h200 + k, $sformatf("wrap%0d", k));
            if (k == 15) check("wrap at 16", w_xfer_count, 4'd0);
        end
        check("wrap count_w4", w_xfer_count, 4'd1);
        check("wrap count_w16", xfer_count, 16'd17);
        check("wrap last lane0", lane(0), 32'h210);
`else
        // Round-robin: in_sel held at 3 is ignored
        out_ready = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            in_sel = 2'd3;
            #1;
            check($sformatf("rr%0d cur_lane", k), cur_lane, 2'(k % 4));
            send(2'd3, 32'h300 + k, $sformatf("rr%0d", k));
            check($sformatf("rr%0d out_valid", k), out_valid, 4'b0001 << (k % 4));
            check($sformatf("rr%0d lane data", k), lane(k % 4), 32'h300 + k);
        end
        check("rr xfer_count", xfer_count, 16'd8);

        // Lane 2 blocked: fill it, then the next word for lane 2 stalls
        out_ready = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            send(2'd3, 32'h400 + k, $sformatf("rrb%0d", k));
        end
        check("rrb lane2 full", out_valid[2], 1'b1);
        in_data  = 32'h406;
        in_valid = 1'b1;
        #1;
        check("rrb cur_lane", cur_lane, 2'd2);
        check("rrb stalled", in_ready, 1'b0);
        tick();
        tick();
        check("rrb no accept", xfer_count, 16'd14);
        check("rrb lane2 hold", lane(2), 32'h402);
        out_ready = 4'b1111;
        #1;
        check("rrb released", in_ready, 1'b1);
        $display("xfer rrb6 lane=2 data=00000406");
        tick();
        in_valid = 1'b0;
        check("rrb lane2 new", lane(2), 32'h406);
        check("rrb out_valid2", out_valid[2], 1'b1);
        check("rrb xfer_count", xfer_count, 16'd15);
        check("rrb next lane", cur_lane, 2'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
